hexdisp_ctrl: RTL and testbench
===============================

HEXDISP_CTRL -- requirements
Module: hexdisp_ctrl

Interface
REQ-001 The module SHALL have parameter NDIGITS, default 2: number of hex digits driven (1..8).
REQ-002 The module SHALL have parameter DIV, default 5000000: fastclk cycles per tick (2..2^26).
REQ-003 The module SHALL have parameter BLINK_TICKS, default 5: ticks per blink half-period (1..255).
REQ-004 fastclk  input  1  system clock; all state changes on its rising edge.
REQ-005 nReset  input  1  asynchronous, active-low reset.
REQ-006 value  input  4*NDIGITS  data to display; nibble k drives digit k (nibble 0 = bits 3:0).
REQ-007 mode  input  2  display mode: 00 LIVE, 01 HOLD, 10 BLINK, 11 LIVE (reserved).
REQ-008 sample  input  1  synchronous single-cycle capture strobe, used in HOLD only.
REQ-009 lzb  input  1  leading-zero blanking enable.
REQ-010 tick  output  1  one-fastclk-cycle pulse every DIV cycles; slow clock enable for the processor.
REQ-011 hex  output  7*NDIGITS  registered active-low segments; digit k uses bits 7k+6:7k, bit order a..g (bit 0 = a).

Function
REQ-012 Divider counter SHALL count 0..DIV-1 and wrap to 0; tick SHALL be 1 exactly in the cycle the counter equals DIV-1.
REQ-013 Tick period SHALL be exactly DIV cycles, with no drift across wrap.
REQ-014 Display register disp SHALL load value in any cycle where tick=1 and mode is LIVE, BLINK or 11.
REQ-015 In HOLD, disp SHALL load value only in cycles where sample=1, independent of tick.
REQ-016 sample SHALL be ignored in all modes other than HOLD.
REQ-017 Blink state SHALL comprise tick counter bcnt (0..BLINK_TICKS-1) and phase bit; in BLINK, each tick SHALL advance bcnt, and on wrap from BLINK_TICKS-1 to 0 SHALL toggle phase.
REQ-018 In any mode other than BLINK, bcnt and phase SHALL be held at 0, so the display is on the first cycle after leaving BLINK.
REQ-019 When phase=1, all segments of all digits SHALL be off (all ones).
REQ-020 With lzb=1, digit k (k>=1) SHALL be blanked when nibbles k..NDIGITS-1 of disp are all zero; digit 0 SHALL never be blanked by lzb.
REQ-021 Non-blanked digits SHALL show standard hex glyphs 0-9, A, b, C, d, E, F.
REQ-022 hex SHALL be registered: it reflects disp, phase and lzb one fastclk cycle after they change; value-to-hex latency is therefore 2 cycles from the load cycle.
REQ-023 lzb SHALL act on every cycle, not only on ticks.
REQ-024 A mode change SHALL take effect in the next cycle; the divider SHALL keep running across mode changes.

Reset
REQ-025 While nReset=0: divider counter 0, tick 0, disp 0, bcnt 0, phase 0, hex all ones (all digits dark).
REQ-026 After nReset deasserts, first tick SHALL occur in cycle DIV (counter restarts at 0); hex SHALL show "0" on every digit (or digit 0 only if lzb=1) one cycle after release.
REQ-027 Reset asserted mid-blink or mid-count SHALL discard all progress, with no partial tick pulse.

Verification (DIV=4, BLINK_TICKS=2, NDIGITS=2)
REQ-028 Release reset, run 20 cycles -> tick high in cycles 3, 7, 11, 15, 19 only; each pulse 1 cycle wide.
REQ-029 LIVE, value=8'h3A, lzb=0 -> after next tick plus 1 cycle, hex digit1=0110000 (a..g "3"), digit0 glyph "A"; value change between ticks does not alter hex.
REQ-030 HOLD, value=8'h05, sample pulse, then value=8'hFF for 3 ticks -> hex stays "05"; with lzb=1 digit1 dark, digit0 "5".
REQ-031 BLINK, value=8'h12 -> hex on for 2 ticks, all ones for 2 ticks, repeating; switch to LIVE during dark phase -> digits visible next cycle.
REQ-032 Assert nReset during BLINK dark phase, release -> hex all ones during reset, then "00" (lzb=0), first tick after exactly 4 cycles.

Source files
------------

// File: rtl/hexdisp_ctrl.sv
// hexdisp_ctrl: seven-segment hex display controller with a clock-enable divider.
//
// A free-running divider produces a one-cycle 'tick' every DIV fastclk cycles.
// A display register (disp) captures 'value' either on ticks (LIVE, BLINK and
// the reserved mode) or on a 'sample' strobe (HOLD). In BLINK, a tick counter
// toggles a blink phase every BLINK_TICKS ticks; while the phase is set, every
// segment is dark. Leading-zero blanking (lzb) darkens upper digits whose
// nibble and all nibbles above it are zero. The segment outputs are registered.
//
// Ports:
//   fastclk  in   system clock, rising edge
//   nReset   in   asynchronous active-low reset
//   value    in   [4*NDIGITS-1:0] data; nibble k drives digit k
//   mode     in   [1:0] 00 LIVE, 01 HOLD, 10 BLINK, 11 LIVE
//   sample   in   capture strobe, only used in HOLD
//   lzb      in   leading-zero blanking enable
//   tick     out  one-cycle pulse every DIV cycles
//   hex      out  [7*NDIGITS-1:0] active-low segments, digit k at 7k+6:7k, bit 0 = a
module hexdisp_ctrl #(
  parameter int NDIGITS     = 2,
  parameter int DIV         = 5000000,
  parameter int BLINK_TICKS = 5
) (
  input  logic                   fastclk,
  input  logic                   nReset,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [1:0]             mode,
  input  logic                   sample,
  input  logic                   lzb,
  output logic                   tick,
  output logic [7*NDIGITS-1:0]   hex
);

  localparam int CNT_W  = $clog2(DIV);
  localparam int BCNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_TICKS - 1);

  localparam logic [1:0] MODE_HOLD  = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [4*NDIGITS-1:0]   disp_q, disp_d;
  logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
  logic                   phase_q, phase_d;
  logic [7*NDIGITS-1:0]   hex_q, hex_d;

  // Active-low glyph for one nibble, bit order g..a (bit 0 = a).
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Divider: tick is decoded from the counter, so it can never be a partial
  // pulse and is low whenever the counter is held at 0 by reset.
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // Display register: HOLD captures on sample only; every other mode on tick.
  always_comb begin
    disp_d = disp_q;
    if ((mode == MODE_HOLD) ? sample : tick) begin
      disp_d = value;
    end
  end

  // Blink state only advances in BLINK and is cleared otherwise, so leaving
  // BLINK always lands in the visible phase.
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (mode != MODE_BLINK) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      if (bcnt_q == BCNT_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BCNT_W'(1);
      end
    end
  end

  // Segment decode. Walking from the top digit down, upper_zero stays set
  // while every nibble seen so far is zero; digit 0 is exempt from blanking.
  always_comb begin : hex_decode
    logic upper_zero;
    hex_d      = '1;
    upper_zero = 1'b1;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (disp_q[4*k +: 4] == 4'h0);
      if (!phase_q && !(lzb && upper_zero && (k != 0))) begin
        hex_d[7*k +: 7] = seg7(disp_q[4*k +: 4]);
      end
    end
  end

  always_ff @(posedge fastclk or negedge nReset) begin
    if (!nReset) begin
      cnt_q   <= '0;
      disp_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      hex_q   <= '1;
    end else begin
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      hex_q   <= hex_d;
    end
  end

  assign hex = hex_q;

endmodule

// File: tb/tb_hexdisp_ctrl.sv
// Bench for hexdisp_ctrl with NDIGITS=2, DIV=4, BLINK_TICKS=2.
// A cycle-level behavioural model (edge counts, tick counts, a glyph table)
// runs beside the DUT; one process compares tick and hex on every falling edge.
// Directed scenarios add hand-computed literal expectations.
module tb_hexdisp_ctrl;

  localparam int NDIG = 2;
  localparam int DIVP = 4;
  localparam int BT   = 2;
  localparam int VW   = 4 * NDIG;
  localparam int HW   = 7 * NDIG;
  localparam logic [HW-1:0] DARK = '1;

  // Active-high lit segments (bit 0 = a) for 0..F.
  localparam logic [6:0] LIT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                      7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                      7'h39, 7'h5E, 7'h79, 7'h71};

  // ---------------- clock / reset ----------------
  logic          fastclk = 1'b0;
  logic          nReset  = 1'b0;
  logic [VW-1:0] value   = '0;
  logic [1:0]    mode    = 2'b00;
  logic          sample  = 1'b0;
  logic          lzb     = 1'b0;
  logic          tick;
  logic [HW-1:0] hex;

  always #5 fastclk = ~fastclk;

  hexdisp_ctrl #(.NDIGITS(NDIG), .DIV(DIVP), .BLINK_TICKS(BT)) dut (
    .fastclk (fastclk),
    .nReset  (nReset),
    .value   (value),
    .mode    (mode),
    .sample  (sample),
    .lzb     (lzb),
    .tick    (tick),
    .hex     (hex)
  );

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_cnt;   // rising edges since reset release
  logic [VW-1:0] m_disp;
  int            m_bt;    // ticks seen since entering BLINK
  logic [HW-1:0] m_hex;

  function automatic logic [HW-1:0] render(input logic [VW-1:0] d, input bit dark, input bit lz);
    logic [HW-1:0] r;
    r = '1;
    if (!dark) begin
      for (int k = 0; k < NDIG; k++) begin
        if (!(lz && k > 0 && (d >> (4 * k)) == '0)) r[7*k +: 7] = ~LIT[int'(d[4*k +: 4])];
      end
    end
    return r;
  endfunction

  always @(posedge fastclk or negedge nReset) begin
    if (!nReset) begin
      m_cnt  <= 0;
      m_disp <= '0;
      m_bt   <= 0;
      m_hex  <= '1;
    end else begin
      m_hex <= render(m_disp, ((m_bt / BT) % 2) == 1, lzb);
      if ((mode == 2'b01) ? sample : (m_cnt % DIVP == DIVP - 1)) m_disp <= value;
      if (mode == 2'b10) begin
        if (m_cnt % DIVP == DIVP - 1) m_bt <= m_bt + 1;
      end else begin
        m_bt <= 0;
      end
      m_cnt <= m_cnt + 1;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge fastclk) begin
    if (chk_en) begin
      check("tick_model", {31'b0, tick}, {31'b0, (nReset && (m_cnt % DIVP == DIVP - 1))});
      check("hex_model", {18'b0, hex}, {18'b0, m_hex});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge fastclk);
    #1;
  endtask

  task automatic wait_tick(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * DIVP && !seen; i++) begin
      @(negedge fastclk);
      if (tick === 1'b1) seen = 1'b1;
    end
    check(name, {31'b0, seen}, 32'd1);
  endtask

  task automatic wait_dark(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge fastclk);
      if (hex === DARK) seen = 1'b1;
    end
    check(name, {31'b0, seen}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int tick_cycles[$];
    int exp_ticks[5];
    int dark_n, lit_n, first_tick;

    exp_ticks = '{3, 7, 11, 15, 19};
    nReset = 1'b0;
    repeat (3) next_cycle();
    chk_en = 1'b1;
    @(negedge fastclk);
    check("reset_hex", {18'b0, hex}, {18'b0, DARK});
    check("reset_tick", {31'b0, tick}, 32'd0);

    // Release and watch the tick pattern for 20 cycles.
    next_cycle();
    nReset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge fastclk);
      if (tick === 1'b1) tick_cycles.push_back(c);
      if (c == 1) check("release_hex_00", {18'b0, hex}, {18'b0, 7'h40, 7'h40});
    end
    check("tick_count", tick_cycles.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("tick_cycle", (i < tick_cycles.size()) ? tick_cycles[i] : -1, exp_ticks[i]);
    end

    // LIVE: value 3A shows after the next tick; a change between ticks is ignored.
    next_cycle();
    mode = 2'b00; value = 8'h3A; lzb = 1'b0;
    wait_tick("live_tick_seen");
    next_cycle();
    value = 8'h77;
    @(negedge fastclk);
    @(negedge fastclk);
    check("live_3A", {18'b0, hex}, {18'b0, 7'h30, 7'h08});
    @(negedge fastclk);
    check("live_between_ticks", {18'b0, hex}, {18'b0, 7'h30, 7'h08});

    // HOLD: capture 05 on sample, then ignore FF for 3 ticks.
    next_cycle();
    mode = 2'b01; value = 8'h05; sample = 1'b1;
    next_cycle();
    sample = 1'b0; value = 8'hFF;
    repeat (3 * DIVP + 1) next_cycle();
    @(negedge fastclk);
    check("hold_05", {18'b0, hex}, {18'b0, 7'h40, 7'h12});
    next_cycle();
    lzb = 1'b1;
    @(negedge fastclk);
    @(negedge fastclk);
    check("hold_05_lzb", {18'b0, hex}, {18'b0, 7'h7F, 7'h12});

    // BLINK: 16-cycle period, half dark, half "12".
    next_cycle();
    mode = 2'b10; value = 8'h12; lzb = 1'b0;
    repeat (16) @(negedge fastclk);
    dark_n = 0; lit_n = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge fastclk);
      if (hex === DARK) dark_n++;
      if (hex === {7'h79, 7'h24}) lit_n++;
    end
    check("blink_dark_cycles", dark_n, 32'd16);
    check("blink_lit_cycles", lit_n, 32'd16);

    // Leave BLINK while dark: phase clears, hex follows one cycle later.
    wait_dark("blink_dark_seen");
    next_cycle();
    mode = 2'b00;
    @(negedge fastclk);
    @(negedge fastclk);
    @(negedge fastclk);
    check("live_after_blink", {18'b0, hex}, {18'b0, 7'h79, 7'h24});

    // Reset during a dark blink phase.
    next_cycle();
    mode = 2'b10;
    wait_dark("blink_dark_seen2");
    next_cycle();
    nReset = 1'b0;
    @(negedge fastclk);
    check("midblink_reset_hex", {18'b0, hex}, {18'b0, DARK});
    check("midblink_reset_tick", {31'b0, tick}, 32'd0);
    repeat (2) next_cycle();
    nReset = 1'b1;
    first_tick = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge fastclk);
      if (tick === 1'b1 && first_tick < 0) first_tick = c;
      if (c == 1) check("rerelease_hex_00", {18'b0, hex}, {18'b0, 7'h40, 7'h40});
    end
    check("rerelease_first_tick", first_tick, 32'd3);

    // Randomized traffic against the model.
    for (int i = 0; i < 1200; i++) begin
      next_cycle();
      case ($urandom_range(0, 3))
        0: value = VW'($urandom_range(0, 15));
        1: value = '0;
        default: value = VW'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      sample = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) lzb = ~lzb;
      nReset = ($urandom_range(0, 249) != 0);
    end
    next_cycle();
    nReset = 1'b1;
    repeat (8) next_cycle();
    @(negedge fastclk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
